top_core: RTL and testbench

//  Registered multi-function datapath at the top of the fuzz-rewiring test

---
 rtl/top_core_pkg.sv | 50 +++++
 rtl/top_core_bit_stats.sv | 39 +++
 rtl/top_core.sv | 121 ++++++++++++
 tb/tb_top_core.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/top_core_pkg.sv
// -----------------------------------------------------------------------------
// top_core_pkg
// Shared definitions for the top_core datapath. Holds the bit offsets for the
// 138-bit input bus and the 159-bit result bus, the control-field bit indices,
// and the packed control struct.
// -----------------------------------------------------------------------------
package top_core_pkg;

    // Input bus field offsets. All offsets assume a 32-bit operand width.
    localparam int A_LSB    = 0;
    localparam int B_LSB    = 32;
    localparam int C_LSB    = 64;
    localparam int D_LSB    = 96;
    localparam int CTRL_LSB = 128;
    localparam int CTRL_W   = 10;
    localparam int IN_W     = 138;

    // Result bus field offsets.
    localparam int SUM_LSB  = 0;
    localparam int ROT_LSB  = 33;
    localparam int ACC_LSB  = 65;
    localparam int SEL_LSB  = 97;
    localparam int CNT_LSB  = 129;
    localparam int POP_LSB  = 145;
    localparam int CLZ_LSB  = 151;
    localparam int PAR_BIT  = 157;
    localparam int EQ_BIT   = 158;
    localparam int OUT_W    = 159;

    // Width of the popcount / leading-zero results (must hold 0..32).
    localparam int STAT_W   = 6;

    // Control-field bit indices.
    localparam int ROT_AMT  = 0;   // [4:0] rotate amount
    localparam int ACC_ADD  = 5;
    localparam int ACC_CLR  = 6;
    localparam int SEL_INV  = 7;
    localparam int SEL_MAX  = 8;

    // Packed view of ctrl; bit 9 is reserved and only feeds the parity bit.
    typedef struct packed {
        logic       rsvd;
        logic       sel_max;
        logic       sel_inv;
        logic       acc_clr;
        logic       acc_add;
        logic [4:0] rot_amt;
    } ctrl_t;

endpackage

// File: rtl/top_core_bit_stats.sv
// -----------------------------------------------------------------------------
// top_core_bit_stats
// Combinational bit statistics: population count of a and count of leading
// zeros of b (b == 0 yields W).
// Ports:
//   a    in  W       operand for popcount
//   b    in  W       operand for leading-zero count
//   pop  out STAT_W  number of 1 bits in a
//   clz  out STAT_W  leading zeros of b
// -----------------------------------------------------------------------------
module top_core_bit_stats
    import top_core_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic [STAT_W-1:0] pop,
    output logic [STAT_W-1:0] clz
);

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + STAT_W'(a[i]);
        end
    end

    // Scan upward so the highest set bit is the last one to write clz.
    always_comb begin
        clz = STAT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                clz = STAT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/top_core.sv
// -----------------------------------------------------------------------------
// top_core
// Registered multi-function datapath. Slices in_flat into four operands and a
// control field and produces sum, rotate, accumulate, min/max select, cycle
// count, popcount, leading-zero count, parity and equality results, all
// registered with one cycle of latency. There is no handshake: a new input is
// taken on every rising clock edge.
// Ports:
//   clk       in   1    rising-edge clock
//   rst_n     in   1    asynchronous active-low reset, clears every flop
//   in_flat   in   138  a=[31:0] b=[63:32] c=[95:64] d=[127:96] ctrl=[137:128]
//   out_flat  out  159  {eq, par, clz, pop, cnt, sel, acc, rot, sum}
// Build option:
//   ACC_SATURATE_EN  when defined, the accumulator add saturates at all-ones
//                    instead of wrapping; clear still takes priority.
// -----------------------------------------------------------------------------
module top_core
    import top_core_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_flat,
    output logic [OUT_W-1:0]  out_flat
);

    logic [W-1:0]      a, b, c, d;
    ctrl_t             ctrl;
    logic [2*W-1:0]    rot_wide;
    logic [W:0]        acc_sum;
    logic [W-1:0]      sel_raw;
    logic [STAT_W-1:0] pop_c, clz_c;

    logic [W:0]        sum_d, sum_q;
    logic [W-1:0]      rot_d, rot_q;
    logic [W-1:0]      acc_d, acc_q;
    logic [W-1:0]      sel_d, sel_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [STAT_W-1:0] pop_d, pop_q;
    logic [STAT_W-1:0] clz_d, clz_q;
    logic              par_d, par_q;
    logic              eq_d, eq_q;

    top_core_bit_stats #(.W(W)) u_bit_stats (
        .a   (a),
        .b   (b),
        .pop (pop_c),
        .clz (clz_c)
    );

    always_comb begin
        a    = in_flat[A_LSB +: W];
        b    = in_flat[B_LSB +: W];
        c    = in_flat[C_LSB +: W];
        d    = in_flat[D_LSB +: W];
        ctrl = ctrl_t'(in_flat[CTRL_LSB +: CTRL_W]);

        sum_d = {1'b0, a} + {1'b0, b};

        // Rotate by shifting a doubled copy; the upper half is the result.
        rot_wide = {c, c} << ctrl.rot_amt;
        rot_d    = rot_wide[2*W-1:W];

        acc_sum = {1'b0, acc_q} + {1'b0, d};
        if (ctrl.acc_clr) begin
            acc_d = '0;
        end else if (ctrl.acc_add) begin
`ifdef ACC_SATURATE_EN
            acc_d = acc_sum[W] ? '1 : acc_sum[W-1:0];
`else
            acc_d = acc_sum[W-1:0];
`endif
        end else begin
            acc_d = acc_q;
        end

        // Strict compares so that a tie selects a in both modes.
        if (ctrl.sel_max) begin
            sel_raw = (b > a) ? b : a;
        end else begin
            sel_raw = (b < a) ? b : a;
        end
        sel_d = ctrl.sel_inv ? ~sel_raw : sel_raw;

        cnt_d = cnt_q + 1'b1;
        pop_d = pop_c;
        clz_d = clz_c;
        // Parity over the whole bus, written via ctrl so the reserved bit is consumed.
        par_d = ^{ctrl, in_flat[CTRL_LSB-1:0]};
        eq_d  = (a == c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            rot_q <= '0;
            acc_q <= '0;
            sel_q <= '0;
            cnt_q <= '0;
            pop_q <= '0;
            clz_q <= '0;
            par_q <= 1'b0;
            eq_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            rot_q <= rot_d;
            acc_q <= acc_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            pop_q <= pop_d;
            clz_q <= clz_d;
            par_q <= par_d;
            eq_q  <= eq_d;
        end
    end

    assign out_flat = {eq_q, par_q, clz_q, pop_q, cnt_q, sel_q, acc_q, rot_q, sum_q};

endmodule

// File: tb/tb_top_core.sv
module tb_top_core;
    import top_core_pkg::*;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [IN_W-1:0]   in_flat = '0;
    logic [OUT_W-1:0]  out_flat;

    always #5 clk = ~clk;

    top_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_flat  (in_flat),
        .out_flat (out_flat)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [15:0] exp_cnt = '0;

    typedef struct {
        logic [31:0] a, b, c, d;
        logic [9:0]  ctrl;
        logic [32:0] sum;
        logic [31:0] rot, sel;
        logic [5:0]  pop, clz;
        logic        par, eq;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_wide(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [9:0] ctrl);
        in_flat = {ctrl, d, c, b, a};
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 16'd1;
    endtask

    function automatic logic [31:0] f_acc(input logic [OUT_W-1:0] o);
        return o[ACC_LSB +: 32];
    endfunction

    function automatic logic [15:0] f_cnt(input logic [OUT_W-1:0] o);
        return o[CNT_LSB +: 16];
    endfunction

    initial begin
        //                a             b             c             d    ctrl     sum             rot           sel           pop    clz    par  eq
        vecs[0] = '{32'hFFFF_FFFF, 32'h1,        32'h8000_0001, 32'h0, 10'h001, 33'h1_0000_0000, 32'h0000_0003, 32'h1,        6'd32, 6'd31, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h1,        32'h8000_0001, 32'h0, 10'h000, 33'h1_0000_0000, 32'h8000_0001, 32'h1,        6'd32, 6'd31, 1'b1, 1'b0};
        vecs[2] = '{32'h5,         32'h9,        32'h0,         32'h0, 10'h100, 33'hE,           32'h0,         32'h9,        6'd2,  6'd28, 1'b1, 1'b0};
        vecs[3] = '{32'h5,         32'h9,        32'h0,         32'h0, 10'h000, 33'hE,           32'h0,         32'h5,        6'd2,  6'd28, 1'b0, 1'b0};
        vecs[4] = '{32'h5,         32'h9,        32'h0,         32'h0, 10'h080, 33'hE,           32'h0,         32'hFFFF_FFFA, 6'd2, 6'd28, 1'b1, 1'b0};
        vecs[5] = '{32'h1234,      32'h0,        32'h1234,      32'h0, 10'h000, 33'h1234,        32'h1234,      32'h0,        6'd5,  6'd32, 1'b0, 1'b1};
        vecs[6] = '{32'h1234,      32'h0,        32'h1234,      32'h0, 10'h200, 33'h1234,        32'h1234,      32'h0,        6'd5,  6'd32, 1'b1, 1'b1};
        vecs[7] = '{32'h7,         32'h7,        32'h0,         32'h0, 10'h180, 33'hE,           32'h0,         32'hFFFF_FFF8, 6'd3, 6'd29, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 32'h1,        32'h0, 10'h01F, 33'h1_0000_0000, 32'h8000_0000, 32'h8000_0000, 6'd1, 6'd0,  1'b0, 1'b0};
        vecs[9] = '{32'h0,         32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0, 10'h004, 33'hFFFF_FFFF,  32'hEADB_EEFD, 32'h0,        6'd0,  6'd0,  1'b1, 1'b0};

        // ---------------- reset: outputs stay zero under random input ----------------
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_flat = IN_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            @(posedge clk);
            #1;
            chk_wide("reset_out_zero", out_flat, '0);
        end
        in_flat = '0;
        rst_n   = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cnt_after_release", 64'(f_cnt(out_flat)), 64'(exp_cnt));
        end

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].ctrl);
            step();
            chk($sformatf("v%0d_sum", i), 64'(out_flat[SUM_LSB +: 33]), 64'(vecs[i].sum));
            chk($sformatf("v%0d_rot", i), 64'(out_flat[ROT_LSB +: 32]), 64'(vecs[i].rot));
            chk($sformatf("v%0d_sel", i), 64'(out_flat[SEL_LSB +: 32]), 64'(vecs[i].sel));
            chk($sformatf("v%0d_pop", i), 64'(out_flat[POP_LSB +: 6]),  64'(vecs[i].pop));
            chk($sformatf("v%0d_clz", i), 64'(out_flat[CLZ_LSB +: 6]),  64'(vecs[i].clz));
            chk($sformatf("v%0d_par", i), 64'(out_flat[PAR_BIT]),       64'(vecs[i].par));
            chk($sformatf("v%0d_eq", i),  64'(out_flat[EQ_BIT]),        64'(vecs[i].eq));
            chk($sformatf("v%0d_cnt", i), 64'(f_cnt(out_flat)),         64'(exp_cnt));
        end

        // ---------------- accumulator sequence ----------------
        drive(32'h0, 32'h0, 32'h0, 32'h8000_0000, 10'h040);
        step();
        chk("acc_clear", 64'(f_acc(out_flat)), 64'h0);
        drive(32'h0, 32'h0, 32'h0, 32'h8000_0000, 10'h020);
        step();
        chk("acc_add1", 64'(f_acc(out_flat)), 64'h8000_0000);
        step();
`ifdef ACC_SATURATE_EN
        chk("acc_add2", 64'(f_acc(out_flat)), 64'hFFFF_FFFF);
        step();
        chk("acc_add3", 64'(f_acc(out_flat)), 64'hFFFF_FFFF);
`else
        chk("acc_add2", 64'(f_acc(out_flat)), 64'h0);
        step();
        chk("acc_add3", 64'(f_acc(out_flat)), 64'h8000_0000);
`endif
        drive(32'h0, 32'h0, 32'h0, 32'h8000_0000, 10'h060);
        step();
        chk("acc_clr_wins", 64'(f_acc(out_flat)), 64'h0);
        drive(32'h0, 32'h0, 32'h0, 32'h5, 10'h020);
        step();
        chk("acc_add5", 64'(f_acc(out_flat)), 64'h5);
        drive(32'h0, 32'h0, 32'h0, 32'h7, 10'h000);
        step();
        chk("acc_hold", 64'(f_acc(out_flat)), 64'h5);
        chk("cnt_running", 64'(f_cnt(out_flat)), 64'(exp_cnt));

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk_wide("async_reset_clear", out_flat, '0);
        #2;
        in_flat = '0;
        rst_n   = 1'b1;
        exp_cnt = '0;
        step();
        chk("cnt_after_async", 64'(f_cnt(out_flat)), 64'(exp_cnt));
        chk("acc_after_async", 64'(f_acc(out_flat)), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
